// File: rtl/pipe_id_ex_hz.sv
// ID/EX pipeline register with load-use bubble injection, hold and flush.
// Optional `define PIPE_ID_EX_PERF_EN adds the saturating bubble counter.
module pipe_id_ex_hz #(
   parameter int BITS       = 32,
   parameter int REG_WORDS  = 32,
   parameter int ADDR_LEFT  = $clog2(REG_WORDS) - 1,
   parameter int OP_BITS    = 4,
   parameter int SHIFT_BITS = 5,
   parameter int BE_BITS    = BITS / 8,
   parameter int CNT_BITS   = 16
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  valid_s2,
   input  logic                  hold_in,
   input  logic                  flush,
   input  logic [ADDR_LEFT:0]    raddr1_,
   input  logic [ADDR_LEFT:0]    raddr2_,
   input  logic                  uses_r1,
   input  logic                  uses_r2,
   input  logic                  atomic,
   input  logic                  sel_mem,
   input  logic                  check_link,
   input  logic                  mem_rw_,
   input  logic                  rw_,
   input  logic                  load_link_,
   input  logic                  alu_imm,
   input  logic                  halt_s2,
   input  logic [ADDR_LEFT:0]    waddr_,
   input  logic [BITS-1:0]       r1_data,
   input  logic [BITS-1:0]       r2_data,
   input  logic [BITS-1:0]       sign_ext_imm,
   input  logic [SHIFT_BITS-1:0] shamt,
   input  logic [OP_BITS-1:0]    alu_op,
   input  logic [BE_BITS-1:0]    byte_en,
   output logic                  valid_s3,
   output logic                  atomic_s3,
   output logic                  sel_mem_s3,
   output logic                  check_link_s3,
   output logic                  mem_rw_s3,
   output logic                  rw_s3,
   output logic                  load_link_s3,
   output logic                  alu_imm_s3,
   output logic                  halt_s3,
   output logic [ADDR_LEFT:0]    waddr_s3,
   output logic [BITS-1:0]       r1_data_s3,
   output logic [BITS-1:0]       r2_data_s3,
   output logic [BITS-1:0]       sign_ext_imm_s3,
   output logic [SHIFT_BITS-1:0] shamt_s3,
   output logic [OP_BITS-1:0]    alu_op_s3,
   output logic [BE_BITS-1:0]    byte_en_s3,
   output logic                  stall_s2,
   output logic [CNT_BITS-1:0]   bubble_cnt
);

   logic hit1;
   logic hit2;
   logic load_use;
   logic bubble;
   logic kill;
   logic load_s3;

   assign load_s3  = valid_s3 & sel_mem_s3 & ~rw_s3 & (waddr_s3 != '0);
   assign hit1     = uses_r1 & (raddr1_ == waddr_s3);
   assign hit2     = uses_r2 & (raddr2_ == waddr_s3);
   assign load_use = valid_s2 & load_s3 & (hit1 | hit2);
   assign stall_s2 = hold_in | (load_use & ~flush);
   assign bubble   = ~flush & ~hold_in & load_use;

   // Anything that leaves s3 invalid also forces inert control.
   assign kill = flush | bubble | ~valid_s2;

   always_ff @(posedge clk) begin
      if (!rst_) begin
         valid_s3        <= 1'b0;
         atomic_s3       <= 1'b0;
         sel_mem_s3      <= 1'b0;
         check_link_s3   <= 1'b0;
         mem_rw_s3       <= 1'b1;
         rw_s3           <= 1'b1;
         load_link_s3    <= 1'b1;
         alu_imm_s3      <= 1'b0;
         halt_s3         <= 1'b0;
         waddr_s3        <= '0;
         r1_data_s3      <= '0;
         r2_data_s3      <= '0;
         sign_ext_imm_s3 <= '0;
         shamt_s3        <= '0;
         alu_op_s3       <= '0;
         byte_en_s3      <= '1;
      end else if (flush | ~hold_in) begin
         valid_s3        <= ~kill;
         atomic_s3       <= atomic & ~kill;
         sel_mem_s3      <= sel_mem & ~kill;
         check_link_s3   <= check_link & ~kill;
         mem_rw_s3       <= mem_rw_ | kill;
         rw_s3           <= rw_ | kill;
         load_link_s3    <= load_link_ | kill;
         halt_s3         <= halt_s2 & ~kill;
         byte_en_s3      <= kill ? '1 : byte_en;
         alu_imm_s3      <= alu_imm;
         waddr_s3        <= waddr_;
         r1_data_s3      <= r1_data;
         r2_data_s3      <= r2_data;
         sign_ext_imm_s3 <= sign_ext_imm;
         shamt_s3        <= shamt;
         alu_op_s3       <= alu_op;
      end
   end

`ifdef PIPE_ID_EX_PERF_EN
   logic [CNT_BITS-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_) begin
         cnt <= '0;
      end else if (bubble && (cnt != {CNT_BITS{1'b1}})) begin
         cnt <= cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
      end
   end

   assign bubble_cnt = cnt;
`else
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_id_ex_hz.sv
// Directed bench for pipe_id_ex_hz: reset, advance, load-use, hold, flush, counter.
module tb_pipe_id_ex_hz;

   logic        clk = 1'b0;
   logic        rst_;
   logic        valid_s2, hold_in, flush;
   logic [4:0]  raddr1_, raddr2_, waddr_;
   logic        uses_r1, uses_r2;
   logic        atomic, sel_mem, check_link, mem_rw_, rw_, load_link_;
   logic        alu_imm, halt_s2;
   logic [31:0] r1_data, r2_data, sign_ext_imm;
   logic [4:0]  shamt;
   logic [3:0]  alu_op;
   logic [3:0]  byte_en;
   logic        valid_s3, atomic_s3, sel_mem_s3, check_link_s3;
   logic        mem_rw_s3, rw_s3, load_link_s3, alu_imm_s3, halt_s3;
   logic [4:0]  waddr_s3;
   logic [31:0] r1_data_s3, r2_data_s3, sign_ext_imm_s3;
   logic [4:0]  shamt_s3;
   logic [3:0]  alu_op_s3;
   logic [3:0]  byte_en_s3;
   logic        stall_s2;
   logic [1:0]  bubble_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int model_cnt = 0;

   always #5 clk = ~clk;

   pipe_id_ex_hz #(.CNT_BITS(2)) dut (
      .clk(clk), .rst_(rst_), .valid_s2(valid_s2), .hold_in(hold_in),
      .flush(flush), .raddr1_(raddr1_), .raddr2_(raddr2_),
      .uses_r1(uses_r1), .uses_r2(uses_r2), .atomic(atomic),
      .sel_mem(sel_mem), .check_link(check_link), .mem_rw_(mem_rw_),
      .rw_(rw_), .load_link_(load_link_), .alu_imm(alu_imm),
      .halt_s2(halt_s2), .waddr_(waddr_), .r1_data(r1_data),
      .r2_data(r2_data), .sign_ext_imm(sign_ext_imm), .shamt(shamt),
      .alu_op(alu_op), .byte_en(byte_en), .valid_s3(valid_s3),
      .atomic_s3(atomic_s3), .sel_mem_s3(sel_mem_s3),
      .check_link_s3(check_link_s3), .mem_rw_s3(mem_rw_s3),
      .rw_s3(rw_s3), .load_link_s3(load_link_s3),
      .alu_imm_s3(alu_imm_s3), .halt_s3(halt_s3), .waddr_s3(waddr_s3),
      .r1_data_s3(r1_data_s3), .r2_data_s3(r2_data_s3),
      .sign_ext_imm_s3(sign_ext_imm_s3), .shamt_s3(shamt_s3),
      .alu_op_s3(alu_op_s3), .byte_en_s3(byte_en_s3),
      .stall_s2(stall_s2), .bubble_cnt(bubble_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_s2 = 0; hold_in = 0; flush = 0;
      raddr1_ = 0; raddr2_ = 0; uses_r1 = 0; uses_r2 = 0;
      atomic = 0; sel_mem = 0; check_link = 0;
      mem_rw_ = 1; rw_ = 1; load_link_ = 1; alu_imm = 0; halt_s2 = 0;
      waddr_ = 0; r1_data = 0; r2_data = 0; sign_ext_imm = 0;
      shamt = 0; alu_op = 0; byte_en = 4'hF;
   endtask

   task automatic drive_load(input logic [4:0] wa);
      idle();
      valid_s2 = 1; sel_mem = 1; rw_ = 0; waddr_ = wa;
   endtask

   task automatic check_cnt(input string nm);
      logic [1:0] exp;
`ifdef PIPE_ID_EX_PERF_EN
      exp = 2'(model_cnt);
`else
      exp = 2'd0;
`endif
      n_cmp++;
      if (bubble_cnt !== exp) begin
         n_bad++;
         $display("FAIL %s: bubble_cnt got %0d want %0d", nm, bubble_cnt, exp);
      end
   endtask

   task automatic bump();
      if (model_cnt < 3) model_cnt++;
   endtask

   task automatic test_reset();
      rst_ = 0; hold_in = 0; flush = 0;
      valid_s2 = 1'($urandom); raddr1_ = 5'($urandom); raddr2_ = 5'($urandom);
      uses_r1 = 1; uses_r2 = 1; atomic = 1; sel_mem = 1; check_link = 1;
      mem_rw_ = 0; rw_ = 0; load_link_ = 0; alu_imm = 1; halt_s2 = 1;
      waddr_ = 5'($urandom); r1_data = $urandom; r2_data = $urandom;
      sign_ext_imm = $urandom; shamt = 5'($urandom); alu_op = 4'hA;
      byte_en = 4'h3;
      step(); step();
      n_cmp += 7;
      if (valid_s3 !== 0) begin n_bad++; $display("FAIL rst valid_s3 got %b want 0", valid_s3); end
      if (rw_s3 !== 1) begin n_bad++; $display("FAIL rst rw_s3 got %b want 1", rw_s3); end
      if (mem_rw_s3 !== 1) begin n_bad++; $display("FAIL rst mem_rw_s3 got %b want 1", mem_rw_s3); end
      if (load_link_s3 !== 1) begin n_bad++; $display("FAIL rst load_link_s3 got %b want 1", load_link_s3); end
      if (byte_en_s3 !== 4'hF) begin n_bad++; $display("FAIL rst byte_en_s3 got %h want f", byte_en_s3); end
      if (alu_op_s3 !== 0) begin n_bad++; $display("FAIL rst alu_op_s3 got %h want 0", alu_op_s3); end
      if (stall_s2 !== 0) begin n_bad++; $display("FAIL rst stall_s2 got %b want 0", stall_s2); end
      check_cnt("rst");
      idle();
      rst_ = 1;
      step();
   endtask

   task automatic test_advance();
      idle();
      valid_s2 = 1; r1_data = 32'hDEADBEEF; waddr_ = 5; alu_op = 4'h3;
      step();
      n_cmp += 4;
      if (r1_data_s3 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL adv r1_data_s3 got %h want deadbeef", r1_data_s3); end
      if (waddr_s3 !== 5) begin n_bad++; $display("FAIL adv waddr_s3 got %0d want 5", waddr_s3); end
      if (alu_op_s3 !== 3) begin n_bad++; $display("FAIL adv alu_op_s3 got %0d want 3", alu_op_s3); end
      if (valid_s3 !== 1) begin n_bad++; $display("FAIL adv valid_s3 got %b want 1", valid_s3); end
      idle();
      sel_mem = 1; rw_ = 0; byte_en = 4'h1; alu_op = 4'h9;
      step();
      n_cmp += 4;
      if (valid_s3 !== 0) begin n_bad++; $display("FAIL inv valid_s3 got %b want 0", valid_s3); end
      if (rw_s3 !== 1) begin n_bad++; $display("FAIL inv rw_s3 got %b want 1", rw_s3); end
      if (sel_mem_s3 !== 0) begin n_bad++; $display("FAIL inv sel_mem_s3 got %b want 0", sel_mem_s3); end
      if (alu_op_s3 !== 4'h9) begin n_bad++; $display("FAIL inv alu_op_s3 got %h want 9", alu_op_s3); end
   endtask

   task automatic test_load_use();
      drive_load(7);
      step();
      idle();
      valid_s2 = 1; uses_r2 = 1; raddr2_ = 7; waddr_ = 9; alu_op = 4'h6;
      #1;
      n_cmp++;
      if (stall_s2 !== 1) begin n_bad++; $display("FAIL lu stall_s2 got %b want 1", stall_s2); end
      step();
      bump();
      n_cmp += 3;
      if (valid_s3 !== 0) begin n_bad++; $display("FAIL lu bubble valid_s3 got %b want 0", valid_s3); end
      if (rw_s3 !== 1) begin n_bad++; $display("FAIL lu bubble rw_s3 got %b want 1", rw_s3); end
      if (stall_s2 !== 0) begin n_bad++; $display("FAIL lu after stall_s2 got %b want 0", stall_s2); end
      check_cnt("lu");
      step();
      n_cmp += 3;
      if (valid_s3 !== 1) begin n_bad++; $display("FAIL lu adv valid_s3 got %b want 1", valid_s3); end
      if (alu_op_s3 !== 4'h6) begin n_bad++; $display("FAIL lu adv alu_op_s3 got %h want 6", alu_op_s3); end
      if (waddr_s3 !== 9) begin n_bad++; $display("FAIL lu adv waddr_s3 got %0d want 9", waddr_s3); end
      drive_load(0);
      step();
      idle();
      valid_s2 = 1; uses_r1 = 1; raddr1_ = 0; alu_op = 4'h2;
      #1;
      n_cmp++;
      if (stall_s2 !== 0) begin n_bad++; $display("FAIL lu r0 stall_s2 got %b want 0", stall_s2); end
      step();
      n_cmp++;
      if (valid_s3 !== 1) begin n_bad++; $display("FAIL lu r0 valid_s3 got %b want 1", valid_s3); end
      check_cnt("lu r0");
   endtask

   task automatic test_hold();
      idle();
      valid_s2 = 1; alu_op = 4'h5; waddr_ = 3;
      step();
      idle();
      valid_s2 = 1; alu_op = 4'hC; hold_in = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp += 3;
         if (stall_s2 !== 1) begin n_bad++; $display("FAIL hold stall_s2 got %b want 1", stall_s2); end
         step();
         if (alu_op_s3 !== 4'h5) begin n_bad++; $display("FAIL hold alu_op_s3 got %h want 5", alu_op_s3); end
         if (valid_s3 !== 1) begin n_bad++; $display("FAIL hold valid_s3 got %b want 1", valid_s3); end
      end
      check_cnt("hold");
      drive_load(7);
      step();
      idle();
      valid_s2 = 1; uses_r1 = 1; raddr1_ = 7; alu_op = 4'hB; hold_in = 1;
      step(); step();
      n_cmp += 2;
      if (valid_s3 !== 1) begin n_bad++; $display("FAIL hold+lu valid_s3 got %b want 1", valid_s3); end
      if (sel_mem_s3 !== 1) begin n_bad++; $display("FAIL hold+lu sel_mem_s3 got %b want 1", sel_mem_s3); end
      check_cnt("hold+lu");
      hold_in = 0;
      #1;
      n_cmp++;
      if (stall_s2 !== 1) begin n_bad++; $display("FAIL release stall_s2 got %b want 1", stall_s2); end
      step();
      bump();
      n_cmp++;
      if (valid_s3 !== 0) begin n_bad++; $display("FAIL release valid_s3 got %b want 0", valid_s3); end
      check_cnt("release");
      step();
      n_cmp++;
      if (alu_op_s3 !== 4'hB) begin n_bad++; $display("FAIL release alu_op_s3 got %h want b", alu_op_s3); end
   endtask

   task automatic test_flush();
      drive_load(7);
      step();
      idle();
      valid_s2 = 1; uses_r1 = 1; raddr1_ = 7; mem_rw_ = 0;
      hold_in = 1; flush = 1;
      #1;
      n_cmp++;
      if (stall_s2 !== 1) begin n_bad++; $display("FAIL flush stall_s2 got %b want 1", stall_s2); end
      step();
      n_cmp += 2;
      if (valid_s3 !== 0) begin n_bad++; $display("FAIL flush valid_s3 got %b want 0", valid_s3); end
      if (mem_rw_s3 !== 1) begin n_bad++; $display("FAIL flush mem_rw_s3 got %b want 1", mem_rw_s3); end
      check_cnt("flush");
      idle();
      step();
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 5; i++) begin
         drive_load(7);
         step();
         idle();
         valid_s2 = 1; uses_r1 = 1; raddr1_ = 7;
         step();
         bump();
         step();
      end
      check_cnt("saturate");
   endtask

   initial begin
      idle();
      rst_ = 0;
      test_reset();
      test_advance();
      test_load_use();
      test_hold();
      test_flush();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_id_ex_hz.md
Name: pipe_id_ex_hz

Overview:
Parametrised ID/EX (stage 2 to stage 3) pipeline register with a valid bit, external hold, flush, and built-in load-use hazard detection.
- When stage 3 holds a load whose destination matches a stage-2 source register, the block injects a one-cycle bubble and stalls stage 2.
- Sits between the decoder/regfile read (s2) and the ALU/memory stage (s3).
- Supersedes the fixed-width ID/EX register.

Parameters:
BITS, 32, datapath word width
REG_WORDS, 32, regfile depth
ADDR_LEFT, $clog2(REG_WORDS)-1, MSB of a register address
OP_BITS, 4, ALU opcode width
SHIFT_BITS, 5, shift amount width
BE_BITS, BITS/8, byte-enable width
CNT_BITS, 16, width of the bubble performance counter

Ports:
clk  in  1  system clock
rst_  in  1  reset; synchronous, active-low, sampled on posedge clk
valid_s2  in  1  s2 holds a real instruction
hold_in  in  1  downstream stall: freeze s3, stall s2
flush  in  1  kill the s2 instruction (branch/exception); s3 becomes a bubble
raddr1_, raddr2_  in  ADDR_LEFT+1  s2 source register addresses
uses_r1, uses_r2  in  1  s2 instruction actually reads raddr1_/raddr2_
atomic, sel_mem, check_link, mem_rw_, rw_, load_link_, alu_imm, halt_s2  in  1 each  s2 control
waddr_  in  ADDR_LEFT+1  s2 destination register
r1_data, r2_data, sign_ext_imm  in  BITS  s2 operands
shamt  in  SHIFT_BITS  shift amount
alu_op  in  OP_BITS  ALU operation
byte_en  in  BE_BITS  byte enables
valid_s3  out  1  s3 holds a real instruction
<each s2 field>_s3  out  same width  registered copies (halt_s2 -> halt_s3)
stall_s2  out  1  combinational: s2/IF must hold this cycle
bubble_cnt  out  CNT_BITS  count of load-use bubbles inserted

Behaviour:
- Reset (rst_=0 at posedge), all registers reset:
  - valid_s3=0, rw_s3=1, mem_rw_s3=1, load_link_s3=1, byte_en_s3=all ones.
  - All other _s3 outputs=0 (including data and waddr_s3).
  - bubble_cnt=0.
  - stall_s2=0 while s3 is invalid.
  - Reset mid-stall/mid-bubble overrides everything.
- Load-use hazard (combinational): load_use = valid_s2 & valid_s3 & sel_mem_s3 & rw_s3==0 & waddr_s3!=0 & ((uses_r1 & raddr1_==waddr_s3) | (uses_r2 & raddr2_==waddr_s3)).
- stall_s2 = hold_in | (load_use & ~flush).
- Per-posedge priority, highest first:
  1. Reset.
  2. flush: valid_s3<=0; control forced to safe values (rw_s3=1, mem_rw_s3=1, load_link_s3=1, atomic/check_link/sel_mem/halt_s3=0, byte_en_s3=all ones); data fields don't-care. Flush also overrides hold_in.
  3. hold_in: every s3 register holds its value, valid included.
  4. load_use: bubble with the same safe values as flush; bubble_cnt increments.
  5. Otherwise advance: every _s3 <= its s2 input; valid_s3 <= valid_s2.
- Advance with valid_s2=0: fields are still captured, but valid_s3=0 and control is forced to the safe values. An invalid s3 never writes the regfile or memory.
- Latency: 1 cycle s2 -> s3 on advance.
- Bubble length: a load-use bubble lasts exactly 1 cycle. The bubble makes s3 invalid, so the hazard clears on the next cycle.
- Simultaneous hold_in and load_use: hold wins; no bubble, no count. The hazard is re-evaluated after the hold releases.
- Register 0 is hardwired; a destination of 0 never creates a hazard.
- bubble_cnt saturates at all ones and does not wrap.

Optional Feature:
PIPE_ID_EX_PERF_EN
- Defined: bubble_cnt implemented as described.
- Undefined: no counter flops; bubble_cnt tied to 0. Hazard, stall and bubble behaviour unchanged.

Test Plan:
- Reset: drive rst_=0 for 2 cycles with random inputs -> valid_s3=0, rw_s3=1, mem_rw_s3=1, load_link_s3=1, byte_en_s3=4'hF, alu_op_s3=0, bubble_cnt=0, stall_s2=0.
- Advance: valid_s2=1, r1_data=32'hDEADBEEF, waddr_=5, alu_op=4'h3 -> next cycle r1_data_s3=32'hDEADBEEF, waddr_s3=5, alu_op_s3=3, valid_s3=1.
- Load-use: s3 holds load (sel_mem=1, rw_=0, waddr=7); s2 has uses_r2=1, raddr2_=7 -> stall_s2=1 that cycle; next cycle valid_s3=0, rw_s3=1; following cycle the s2 instruction advances; bubble_cnt=1. Same case with waddr=0 -> no stall.
- Hold: hold_in=1 for 3 cycles while s3 holds alu_op 4'h5 -> s3 outputs unchanged, stall_s2=1, bubble_cnt unchanged. Repeat with a load-use present -> no bubble until the release.
- Flush priority: flush=1 together with hold_in=1 and load_use=1 -> valid_s3=0, mem_rw_s3=1, stall_s2=1 (from hold), bubble_cnt unchanged.
- Saturation (PIPE_ID_EX_PERF_EN, CNT_BITS=2): 5 load-use bubbles -> bubble_cnt=3. Without the macro -> bubble_cnt=0 throughout.
